// File: rtl/ysyx_24080006_icache.sv
// Direct-mapped instruction cache in front of the IFU, refilling over the AXI read channel.
// Define YSYX_ICACHE_EN to build the cache; without it every fetch is a single-beat bypass read.
package ysyx_24080006_icache_pkg;
    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
    } axi_r_s2m_t;
endpackage

module ysyx_24080006_icache
    import ysyx_24080006_icache_pkg::*;
#(
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fencei,
    input  logic [31:0] fetch_addr,
    input  logic        ifu2icu_valid,
    output logic        icu2ifu_ready,
    output logic        icu2ifu_valid,
    output logic [31:0] ic_val,
    input  logic        ifu2icu_ready,
    output logic        icache_hit,
    output logic        icache_miss,
    output logic        icache_skip,
    output axi_r_m2s_t  ifu_r_m2s,
    input  axi_r_s2m_t  ifu_r_s2m
);
    typedef enum logic [2:0] {IC_IDLE, IC_LOOKUP, IC_AR, IC_R, IC_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        skip_q, skip_d;
    logic [31:0] ic_val_q, ic_val_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q;
    logic [1:0]  arburst_q;
    logic        arvalid_q, rready_q, ready_q, valid_q_o;
    logic        hit_q, miss_q, skipp_q;
    logic        hit_d, miss_d, skipp_d, valid_d;

    logic        lookup_skip_c, lookup_hit_c, beat_match_c;
    logic [31:0] lookup_word_c, line_addr_c;
    logic        unused_c;

`ifdef YSYX_ICACHE_EN
    localparam int unsigned OFS = $clog2(LINE_WORDS) + 2;
    localparam int unsigned IDX = $clog2(SETS);
    localparam int unsigned TAG = 32 - IDX - OFS;
    localparam int unsigned WW  = $clog2(LINE_WORDS);

    logic [SETS-1:0] valid_bits_q;
    logic [TAG-1:0]  tag_q  [SETS];
    logic [31:0]     data_q [SETS*LINE_WORDS];
    logic [WW-1:0]   beat_q;
    logic            err_q, fence_q;

    logic [IDX-1:0]  idx_c;
    logic [TAG-1:0]  tag_c;
    logic [WW-1:0]   wsel_c;
    logic            beat_fire_c;

    function automatic logic is_cacheable(input logic [31:0] a);
        return (a[31:24] == 8'h30) || (a[31:26] == 6'b101000);
    endfunction

    assign idx_c         = addr_q[OFS +: IDX];
    assign tag_c         = addr_q[31:OFS];
    assign wsel_c        = addr_q[OFS-1:2];
    assign lookup_skip_c = !is_cacheable(addr_q);
    assign lookup_hit_c  = valid_bits_q[idx_c] && (tag_q[idx_c] == tag_c);
    assign lookup_word_c = data_q[{idx_c, wsel_c}];
    assign line_addr_c   = addr_q & ~32'(LINE_WORDS * 4 - 1);
    assign beat_match_c  = (beat_q == wsel_c);
    assign beat_fire_c   = (state_q == IC_R) && ifu_r_s2m.rvalid && !skip_q;
    assign unused_c      = ^addr_q[1:0];

    // Valid bits and refill bookkeeping; a fencei anywhere in the refill keeps the line invalid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_bits_q <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            fence_q      <= 1'b0;
        end else begin
            if (state_q == IC_LOOKUP) begin
                beat_q  <= '0;
                err_q   <= 1'b0;
                fence_q <= 1'b0;
            end
            if ((state_q == IC_AR || state_q == IC_R) && fencei) fence_q <= 1'b1;
            if (beat_fire_c) begin
                beat_q <= beat_q + WW'(1);
                if (ifu_r_s2m.rresp != 2'b00) err_q <= 1'b1;
                if (ifu_r_s2m.rlast)
                    valid_bits_q[idx_c] <= !err_q && (ifu_r_s2m.rresp == 2'b00) && !fence_q && !fencei;
            end
            if (fencei) valid_bits_q <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (beat_fire_c) begin
            data_q[{idx_c, beat_q}] <= ifu_r_s2m.rdata;
            if (ifu_r_s2m.rlast) tag_q[idx_c] <= tag_c;
        end
    end
`else
    assign lookup_skip_c = 1'b1;
    assign lookup_hit_c  = 1'b0;
    assign lookup_word_c = '0;
    assign line_addr_c   = '0;
    assign beat_match_c  = 1'b1;
    assign unused_c      = ^{fencei, ifu_r_s2m.rresp, addr_q[1:0], 32'(SETS), 32'(LINE_WORDS)};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IC_IDLE;
        else        state_q <= state_d;
    end

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        skip_d   = skip_q;
        ic_val_d = ic_val_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        skipp_d  = 1'b0;
        valid_d  = 1'b0;
        case (state_q)
            IC_IDLE: begin
                if (ifu2icu_valid) begin
                    addr_d  = fetch_addr;
                    state_d = IC_LOOKUP;
                end
            end
            IC_LOOKUP: begin
                if (lookup_skip_c) begin
                    skip_d   = 1'b1;
                    araddr_d = {addr_q[31:2], 2'b00};
                    arlen_d  = 8'd0;
                    state_d  = IC_AR;
                end else if (lookup_hit_c) begin
                    ic_val_d = lookup_word_c;
                    hit_d    = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = IC_IDLE;
                end else begin
                    skip_d   = 1'b0;
                    miss_d   = 1'b1;
                    araddr_d = line_addr_c;
                    arlen_d  = 8'(LINE_WORDS - 1);
                    state_d  = IC_AR;
                end
            end
            IC_AR: begin
                if (ifu_r_s2m.arready) state_d = IC_R;
            end
            IC_R: begin
                if (ifu_r_s2m.rvalid) begin
                    if (skip_q || beat_match_c) ic_val_d = ifu_r_s2m.rdata;
                    if (ifu_r_s2m.rlast) begin
                        skipp_d = skip_q;
                        state_d = IC_RESP;
                    end
                end
            end
            IC_RESP: begin
                if (ifu2icu_ready) state_d = IC_IDLE;
            end
            default: state_d = IC_IDLE;
        endcase
        if (state_d == IC_RESP) valid_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            skip_q    <= 1'b0;
            ic_val_q  <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ready_q   <= 1'b1;
            valid_q_o <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            skipp_q   <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            skip_q    <= skip_d;
            ic_val_q  <= ic_val_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            if (state_d == IC_AR) begin
                arsize_q  <= 3'b010;
                arburst_q <= 2'b01;
            end
            arvalid_q <= (state_d == IC_AR);
            rready_q  <= (state_d == IC_R);
            ready_q   <= (state_d == IC_IDLE);
            valid_q_o <= valid_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            skipp_q   <= skipp_d;
        end
    end

    assign icu2ifu_ready     = ready_q;
    assign icu2ifu_valid     = valid_q_o;
    assign ic_val            = ic_val_q;
    assign icache_hit        = hit_q;
    assign icache_miss       = miss_q;
    assign icache_skip       = skipp_q;
    assign ifu_r_m2s.arvalid = arvalid_q;
    assign ifu_r_m2s.araddr  = araddr_q;
    assign ifu_r_m2s.arlen   = arlen_q;
    assign ifu_r_m2s.arsize  = arsize_q;
    assign ifu_r_m2s.arburst = arburst_q;
    assign ifu_r_m2s.rready  = rready_q;
endmodule
